// File: rtl/des_region_sweeper.sv
// -----------------------------------------------------------------------------
// des_region_sweeper
//   Initiator-side controller for one des_block. Sweeps region indices
//   0..NUM_REGIONS-1; for each region it resets the block, holds blk_start for
//   RUN_CYCLES cycles, waits (bounded by TIMEOUT) for blk_valid, captures the
//   block counter and adds it into a saturating sweep total.
//
// Ports
//   clk, rst_n     clock, synchronous active-low reset
//   go             start a new sweep (accepted in IDLE, DONE, ERR)
//   abort          abandon the current sweep (CLEAR, RUN, DRAIN)
//   blk_rst_n      active-low reset to des_block
//   blk_start      start to des_block
//   blk_region     region_select to des_block
//   blk_counter    counter from des_block
//   blk_valid      valid from des_block
//   region_count   last captured blk_counter
//   region_idx     region index belonging to region_count
//   region_done    one-cycle pulse when region_count/region_idx/total update
//   total          saturating sum of captured counts in the current sweep
//   busy           high in CLEAR, RUN, DRAIN
//   done           high in DONE
//   timeout_err    high in ERR (held until the next go)
// -----------------------------------------------------------------------------
module des_region_sweeper #(
  parameter int NUM_REGIONS = 16,
  parameter int RUN_CYCLES  = 1024,
  parameter int TIMEOUT     = 64,
  parameter int CNT_W       = 10,
  parameter int ACC_W       = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic             abort,
  output logic             blk_rst_n,
  output logic             blk_start,
  output logic [3:0]       blk_region,
  input  logic [CNT_W-1:0] blk_counter,
  input  logic             blk_valid,
  output logic [CNT_W-1:0] region_count,
  output logic [3:0]       region_idx,
  output logic             region_done,
  output logic [ACC_W-1:0] total,
  output logic             busy,
  output logic             done,
  output logic             timeout_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  // One cycle counter is shared by CLEAR, RUN and DRAIN; size it for the
  // longest of the three phases.
  localparam int CMAX  = (RUN_CYCLES > TIMEOUT) ? RUN_CYCLES : TIMEOUT;
  localparam int CYC_W = (CMAX > 1) ? $clog2(CMAX + 1) : 1;

  localparam logic [CYC_W-1:0] CLR_LAST = CYC_W'(1);
  localparam logic [CYC_W-1:0] RUN_LAST = CYC_W'(RUN_CYCLES - 1);
  localparam logic [CYC_W-1:0] TO_LAST  = CYC_W'(TIMEOUT - 1);
  localparam logic [3:0]       IDX_LAST = 4'(NUM_REGIONS - 1);

  // Sum is formed one bit wider than either operand so overflow is visible.
  localparam int SW = ((ACC_W > CNT_W) ? ACC_W : CNT_W) + 1;
  localparam logic [SW-1:0] ACC_MAX = SW'({ACC_W{1'b1}});

  logic [2:0]       state;
  logic [CYC_W-1:0] cyc;
  logic [3:0]       idx;
  logic [SW-1:0]    sum_wide;
  logic [ACC_W-1:0] sum_sat;

  assign sum_wide = SW'(total) + SW'(blk_counter);
  assign sum_sat  = (sum_wide > ACC_MAX) ? '1 : sum_wide[ACC_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cyc          <= '0;
      idx          <= '0;
      total        <= '0;
      region_count <= '0;
      region_idx   <= '0;
      region_done  <= 1'b0;
    end else begin
      region_done <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          // go beats a simultaneous abort here because abort is not looked at.
          if (go) begin
            state        <= S_CLEAR;
            cyc          <= '0;
            idx          <= '0;
            total        <= '0;
            region_count <= '0;
            region_idx   <= '0;
          end
        end
        S_CLEAR: begin
          if (abort) begin
            state <= S_IDLE;
          end else if (cyc == CLR_LAST) begin
            state <= S_RUN;
            cyc   <= '0;
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        S_RUN: begin
          if (abort) begin
            state <= S_IDLE;
          end else if (cyc == RUN_LAST) begin
            state <= S_DRAIN;
            cyc   <= '0;
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        S_DRAIN: begin
          // abort outranks a same-cycle blk_valid: nothing is captured.
          if (abort) begin
            state <= S_IDLE;
          end else if (blk_valid) begin
            region_count <= blk_counter;
            region_idx   <= idx;
            total        <= sum_sat;
            region_done  <= 1'b1;
            cyc          <= '0;
            if (idx == IDX_LAST) begin
              state <= S_DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= S_CLEAR;
            end
          end else if (cyc == TO_LAST) begin
            state <= S_ERR;
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign blk_rst_n   = (state == S_RUN) || (state == S_DRAIN);
  assign blk_start   = (state == S_RUN);
  assign blk_region  = idx;
  assign busy        = (state == S_CLEAR) || (state == S_RUN) || (state == S_DRAIN);
  assign done        = (state == S_DONE);
  assign timeout_err = (state == S_ERR);

endmodule
